// File: rtl/rs_enc_framer_pkg.sv
// rs_pkg: shared constants, K/R lookup and FSM state type for the RS encoder feeder.
package rs_pkg;

    localparam int SYM_W_MIN = 3;
    localparam int SYM_W_MAX = 8;

    typedef enum logic [1:0] {IDLE, SETUP, DATA, GAP} rs_state_e;

    // Data symbols per codeword for each supported symbol width.
    function automatic logic [7:0] rs_k(input logic [3:0] w);
        case (w)
            4'd3:    return 8'd3;
            4'd4:    return 8'd11;
            4'd5:    return 8'd23;
            4'd6:    return 8'd55;
            4'd7:    return 8'd111;
            4'd8:    return 8'd223;
            default: return 8'd0;
        endcase
    endfunction

    // Parity symbols the encoder appends for each supported symbol width.
    function automatic logic [5:0] rs_r(input logic [3:0] w);
        case (w)
            4'd3, 4'd4: return 6'd4;
            4'd5, 4'd6: return 6'd8;
            4'd7:       return 6'd16;
            4'd8:       return 6'd32;
            default:    return 6'd0;
        endcase
    endfunction

    function automatic logic rs_w_ok(input logic [3:0] w);
        return (int'(w) >= SYM_W_MIN) && (int'(w) <= SYM_W_MAX);
    endfunction

endpackage

// File: rtl/rs_bit_unpack.sv
// rs_bit_unpack: LSB-first bit buffer. Bytes are appended above the valid
// bits, symbols are taken from the bottom. Bits above cnt are always zero,
// so an append can simply OR the shifted byte in.
module rs_bit_unpack #(
    parameter int BUF_W = 16,
    parameter int CNT_W = $clog2(BUF_W + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             emit,
    input  logic             allow,
    input  logic [3:0]       w,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [7:0]       sym,
    output logic [CNT_W-1:0] cnt
);

    logic [BUF_W-1:0] buf_q, buf_d, kept;
    logic [CNT_W-1:0] cnt_q, cnt_d, base;

    // Remove the emitted symbol (or everything on flush), then append the byte.
    always_comb begin
        kept = buf_q;
        base = cnt_q;
        if (flush) begin
            kept = '0;
            base = '0;
        end else if (emit) begin
            kept = buf_q >> w;
            base = cnt_q - CNT_W'(w);
        end
        s_ready = allow && (base <= CNT_W'(8));
        buf_d   = kept;
        cnt_d   = base;
        if (s_valid && s_ready) begin
            buf_d = kept | (BUF_W'(s_data) << base);
            cnt_d = base + CNT_W'(8);
        end
    end

    // Buffer and fill-level registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_q <= '0;
            cnt_q <= '0;
        end else begin
            buf_q <= buf_d;
            cnt_q <= cnt_d;
        end
    end

    assign sym = buf_q[7:0] & ~(8'hFF << w);
    assign cnt = cnt_q;

endmodule

// File: rtl/rs_enc_framer.sv
// rs_enc_framer: unpacks a byte stream into sym_width-bit symbols, emits K
// data symbols per codeword with SOP, then idles for R + GAP_EXTRA cycles.
// Optional RS_FRM_UNDERRUN_PAD_EN: zero-pad starved DATA cycles and pulse
// the underrun port instead of leaving a gap in enc_din_val.
module rs_enc_framer
    import rs_pkg::*;
#(
    parameter int GAP_EXTRA = 2,
    parameter int BUF_W     = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] cfg_sym_width,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic [7:0] enc_din,
    output logic       enc_din_val,
    output logic       enc_din_sop,
    output logic [3:0] enc_sym_width,
    output logic       busy,
    output logic       cfg_err
`ifdef RS_FRM_UNDERRUN_PAD_EN
    ,
    output logic       underrun
`endif
);

    localparam int CNT_W = $clog2(BUF_W + 1);

    rs_state_e        state_q, state_d;
    logic [3:0]       w_q, w_d;
    logic [7:0]       k_q, k_d;
    logic [5:0]       r_q, r_d;
    logic [7:0]       sym_cnt_q, sym_cnt_d;
    logic [7:0]       gap_q, gap_d;
    logic [7:0]       dout_q, dout_d;
    logic             val_q, val_d;
    logic             sop_q, sop_d;
    logic             underrun_q, underrun_d;
    logic             run_q, run_d;

    logic             cfg_ok, allow, flush, emit, pad;
    logic [7:0]       sym;
    logic [CNT_W-1:0] cnt;

    assign cfg_ok = rs_w_ok(cfg_sym_width);
    // run_q keeps the combinational outputs low while in and just out of reset.
    assign allow  = run_q && !(state_q == IDLE && !cfg_ok);

    rs_bit_unpack #(.BUF_W(BUF_W), .CNT_W(CNT_W)) u_unpack (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (flush),
        .emit    (emit),
        .allow   (allow),
        .w       (w_q),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .sym     (sym),
        .cnt     (cnt)
    );

    // Codeword sequencing and next-cycle symbol outputs.
    always_comb begin
        state_d   = state_q;
        w_d       = w_q;
        k_d       = k_q;
        r_d       = r_q;
        sym_cnt_d = sym_cnt_q;
        gap_d     = gap_q;
        run_d     = 1'b1;
        flush     = 1'b0;
        emit      = 1'b0;
        pad       = 1'b0;
        case (state_q)
            IDLE: begin
                if (cfg_ok) begin
                    w_d     = cfg_sym_width;
                    k_d     = rs_k(cfg_sym_width);
                    r_d     = rs_r(cfg_sym_width);
                    // Residual bits are only meaningful at the width they were packed for.
                    flush   = (cfg_sym_width != w_q);
                    state_d = SETUP;
                end
            end
            SETUP: begin
                sym_cnt_d = 8'd0;
                state_d   = DATA;
            end
            DATA: begin
                if (cnt >= CNT_W'(w_q)) begin
                    emit = 1'b1;
                end
`ifdef RS_FRM_UNDERRUN_PAD_EN
                else if (!s_valid) begin
                    pad = 1'b1;
                end
`endif
                if (emit || pad) begin
                    sym_cnt_d = sym_cnt_q + 8'd1;
                    if (sym_cnt_q == k_q - 8'd1) begin
                        gap_d   = 8'(int'(r_q) + GAP_EXTRA - 1);
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                if (gap_q == 8'd0) state_d = IDLE;
                else               gap_d   = gap_q - 8'd1;
            end
            default: state_d = IDLE;
        endcase
        val_d      = emit || pad;
        sop_d      = (emit || pad) && (sym_cnt_q == 8'd0);
        dout_d     = emit ? sym : 8'd0;
        underrun_d = pad;
    end

    // Control and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            w_q        <= '0;
            k_q        <= '0;
            r_q        <= '0;
            sym_cnt_q  <= '0;
            gap_q      <= '0;
            dout_q     <= '0;
            val_q      <= 1'b0;
            sop_q      <= 1'b0;
            underrun_q <= 1'b0;
            run_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            w_q        <= w_d;
            k_q        <= k_d;
            r_q        <= r_d;
            sym_cnt_q  <= sym_cnt_d;
            gap_q      <= gap_d;
            dout_q     <= dout_d;
            val_q      <= val_d;
            sop_q      <= sop_d;
            underrun_q <= underrun_d;
            run_q      <= run_d;
        end
    end

    assign enc_din       = dout_q;
    assign enc_din_val   = val_q;
    assign enc_din_sop   = sop_q;
    assign enc_sym_width = w_q;
    assign busy          = (state_q != IDLE);
    assign cfg_err       = run_q && (state_q == IDLE) && !cfg_ok;
`ifdef RS_FRM_UNDERRUN_PAD_EN
    assign underrun      = underrun_q;
`endif

endmodule

// File: tb/tb_rs_enc_framer.sv
// tb_rs_enc_framer: table-driven codewords, hand-written corner sequences and
// randomized traffic, all checked against a bit-queue reference model.
module tb_rs_enc_framer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] cfg_sym_width = 4'd9;
    logic [7:0] s_data = 8'd0;
    logic       s_valid = 1'b0;
    logic       s_ready, enc_din_val, enc_din_sop, busy, cfg_err;
    logic [7:0] enc_din;
    logic [3:0] enc_sym_width;
    logic       underrun;

    int checks = 0;
    int errors = 0;

    rs_enc_framer dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_sym_width (cfg_sym_width),
        .s_data        (s_data),
        .s_valid       (s_valid),
        .s_ready       (s_ready),
        .enc_din       (enc_din),
        .enc_din_val   (enc_din_val),
        .enc_din_sop   (enc_din_sop),
        .enc_sym_width (enc_sym_width),
        .busy          (busy),
        .cfg_err       (cfg_err)
`ifdef RS_FRM_UNDERRUN_PAD_EN
        ,
        .underrun      (underrun)
`endif
    );
`ifndef RS_FRM_UNDERRUN_PAD_EN
    assign underrun = 1'b0;
`endif

    always #5 clk = ~clk;

    function automatic int k_of(input int w);
        case (w)
            3: return 3;   4: return 11;  5: return 23;
            6: return 55;  7: return 111; 8: return 223;
            default: return 0;
        endcase
    endfunction

    function automatic int r_of(input int w);
        case (w)
            3, 4: return 4;  5, 6: return 8;
            7: return 16;    8: return 32;
            default: return 0;
        endcase
    endfunction

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d want %0d", nm, got, exp);
        end
    endtask

    // ---------------- reference model: the accepted bitstream as a queue ------------
    bit         bq[$];
    bit         pend;
    logic [7:0] pend_d;
    bit         busy_d;
    int         last_w, cw_n, post_cnt, un_cnt;
    bit         gap_seen;
    int         sym_h[3];

    always @(negedge clk) begin
        if (!rst_n) begin
            bq.delete();
            busy_d = 1'b0; last_w = 0; cw_n = 0; post_cnt = 0;
        end else begin
            if (busy && !busy_d) begin
                if (int'(enc_sym_width) != last_w) bq.delete();
                last_w = int'(enc_sym_width);
                cw_n = 0; post_cnt = 0;
            end
            if (enc_din_val) begin
                logic [7:0] ev;
                ev = 8'd0;
                if (underrun) un_cnt++;
                else if (bq.size() < last_w) begin
                    checks++; errors++;
                    $display("FAIL underflow have %0d bits need %0d", bq.size(), last_w);
                end else
                    for (int i = 0; i < last_w; i++) ev[i] = bq.pop_front();
                checks++;
                if (enc_din !== ev || enc_din_sop !== (cw_n == 0) || !busy || cw_n >= k_of(last_w)) begin
                    errors++;
                    $display("FAIL sym idx %0d got %h sop %b want %h sop %b (w %0d)",
                             cw_n, enc_din, enc_din_sop, ev, (cw_n == 0), last_w);
                end
                if (cw_n < 3) sym_h[cw_n] = int'(enc_din);
                cw_n++;
            end
            if (busy && cw_n > 0 && cw_n < k_of(last_w) && !enc_din_val) gap_seen = 1'b1;
            if (busy && cw_n == k_of(last_w)) post_cnt++;
            if (pend) for (int i = 0; i < 8; i++) bq.push_back(pend_d[i]);
            busy_d = busy;
        end
        pend   = rst_n && s_valid && s_ready;
        pend_d = s_data;
    end

    // ---------------- stimulus ----------------
    logic [7:0] gen_val = 8'd0, gen_step = 8'd1;
    int         vprob = 100;
    bit         rand_cfg = 1'b0;

    task automatic step();
        bit acc;
        @(negedge clk);
        acc = s_valid && s_ready;
        @(posedge clk);
        #1;
        if (acc) gen_val = gen_val + gen_step;
        s_data  = gen_val;
        s_valid = ($urandom_range(0, 99) < vprob);
        if (rand_cfg && busy) cfg_sym_width = 4'($urandom_range(0, 15));
    endtask

    // One codeword: configure in IDLE, feed bytes until busy falls.
    task automatic run_cw(input int w, input bit rs, input logic [7:0] st, input logic [7:0] sp,
                          input int prob, input int drop_at);
        int t, drops;
        cfg_sym_width = 4'(w);
        vprob = prob;
        if (rs) begin gen_val = st; gen_step = sp; end
        s_data  = gen_val;
        s_valid = ($urandom_range(0, 99) < prob);
        t = 0; drops = 0;
        while (!busy && t < 20) begin step(); t++; end
        while (busy && t < 5000) begin
            if (drop_at >= 0 && cw_n >= drop_at && drops < 5) begin vprob = 0; drops++; end
            else vprob = prob;
            step(); t++;
        end
        chk("cw_done", int'(t < 20 || busy == 1'b0 && t < 5000), 1);
    endtask

    typedef struct {
        int w; bit rs; logic [7:0] st; logic [7:0] sp;
        int k; int gap; int s0; int s1; int s2;
    } vec_t;
    vec_t vt[9];

    initial begin
        #3_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Expected first symbols derived by hand from the LSB-first rule.
        vt[0] = '{4, 1'b1, 8'h21, 8'h22, 11, 6, 1, 2, 3};
        vt[1] = '{8, 1'b1, 8'h00, 8'h01, 223, 34, 8'h00, 8'h01, 8'h02};
        vt[2] = '{8, 1'b0, 8'h00, 8'h00, 223, 34, 8'hDF, 8'hE0, 8'hE1};
        vt[3] = '{3, 1'b1, 8'hD1, 8'h30, 3, 6, 1, 2, 7};   // D1,01: bits 6,7 of D1 + bit 0 of 01
        vt[4] = '{3, 1'b0, 8'h00, 8'h00, 3, 6, 0, 0, 2};   // residual of 01 then 31
        vt[5] = '{5, 1'b1, 8'h10, 8'h01, 23, 10, 16, 8, 4};
        vt[6] = '{8, 1'b1, 8'hA5, 8'h03, 223, 34, 8'hA5, 8'hA8, 8'hAB};
        vt[7] = '{6, 1'b1, 8'hFF, 8'h00, 55, 10, 63, 63, 63};
        vt[8] = '{7, 1'b1, 8'h80, 8'h01, 111, 18, 0, 3, 10};

        // Reset: every output low even with an invalid width and valid data offered.
        s_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", int'({s_ready, enc_din, enc_din_val, enc_din_sop, enc_sym_width,
                               busy, cfg_err, underrun}), 0);
        rst_n = 1'b1;

        // Invalid width in IDLE: error flagged, no acceptance, nothing emitted.
        for (int i = 0; i < 3; i++) begin
            step();
            chk("cfg_err", int'(cfg_err), 1);
            chk("cfg_err_rdy", int'({s_ready, busy, enc_din_val}), 0);
        end

        for (int i = 0; i < 9; i++) begin
            run_cw(vt[i].w, vt[i].rs, vt[i].st, vt[i].sp, 100, -1);
            chk($sformatf("v%0d_k", i), cw_n, vt[i].k);
            chk($sformatf("v%0d_gap", i), post_cnt, vt[i].gap);
            chk($sformatf("v%0d_s0", i), sym_h[0], vt[i].s0);
            chk($sformatf("v%0d_s1", i), sym_h[1], vt[i].s1);
            chk($sformatf("v%0d_s2", i), sym_h[2], vt[i].s2);
        end

        // Input starved for 5 cycles mid-codeword.
        gap_seen = 1'b0; un_cnt = 0;
        run_cw(4, 1'b1, 8'h21, 8'h22, 100, 3);
        chk("drop_k", cw_n, 11);
`ifdef RS_FRM_UNDERRUN_PAD_EN
        chk("drop_underrun", int'(un_cnt > 0), 1);
`else
        chk("drop_gap", int'(gap_seen), 1);
`endif

        // Reset asserted mid-DATA aborts the codeword.
        cfg_sym_width = 4'd8; gen_val = 8'h10; gen_step = 8'd1; s_valid = 1'b1;
        for (int t = 0; t < 100 && cw_n < 5; t++) step();
        chk("mid_reached", int'(cw_n >= 5), 1);
        rst_n = 1'b0;
        #2;
        chk("mid_rst_outs", int'({s_ready, enc_din, enc_din_val, enc_din_sop, enc_sym_width,
                                 busy, cfg_err, underrun}), 0);
        cfg_sym_width = 4'd9;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_rst_hold", int'({enc_din_val, busy, enc_sym_width}), 0);
        rst_n = 1'b1;
        step();
        run_cw(8, 1'b1, 8'h55, 8'h01, 100, -1);
        chk("post_rst_k", cw_n, 223);
        chk("post_rst_s0", sym_h[0], 8'h55);

        // Randomized widths, rates and mid-codeword cfg noise.
        rand_cfg = 1'b1;
        for (int n = 0; n < 25; n++) begin
            int w;
            w = $urandom_range(3, 8);
            run_cw(w, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), $urandom_range(40, 100), -1);
            chk($sformatf("rnd%0d_k", n), cw_n, k_of(w));
            chk($sformatf("rnd%0d_gap", n), post_cnt, r_of(w) + 2);
        end
        rand_cfg = 1'b0;
        s_valid  = 1'b0;
        repeat (2) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
